// File: rtl/pong_game_ctrl.sv
// Pong game sequencer: synchronises player buttons, gates paddle motion, paces
// serve/point/game-over phases in video frames and keeps both scores.
module pong_game_ctrl #(
  parameter int SERVE_FRAMES = 90,
  parameter int PAUSE_FRAMES = 60,
  parameter int WIN_SCORE    = 7
) (
  input  logic       pixel_clk,
  input  logic       rst,
  input  logic       fsync,
  input  logic       start,
  input  logic       p1_right,
  input  logic       p1_left,
  input  logic       p2_right,
  input  logic       p2_left,
  input  logic       miss_top,
  input  logic       miss_bottom,
  output logic       p1_right_o,
  output logic       p1_left_o,
  output logic       p2_right_o,
  output logic       p2_left_o,
  output logic       ball_en,
  output logic       serve_dir,
  output logic       obj_rst,
  output logic [3:0] score1,
  output logic [3:0] score2,
  output logic       game_over,
  output logic       winner
);

  // state | meaning
  // IDLE  | power-up, waiting for start
  // SERVE | ball frozen and centred, counting SERVE_FRAMES
  // PLAY  | ball live, watching for misses
  // SCORE | point pause, counting PAUSE_FRAMES
  // OVER  | someone reached WIN_SCORE, waiting for start
  typedef enum logic [2:0] {IDLE, SERVE, PLAY, SCORE, OVER} state_t;

  localparam logic [7:0] SERVE_LAST = 8'(SERVE_FRAMES - 1);
  localparam logic [7:0] PAUSE_LAST = 8'(PAUSE_FRAMES - 1);
  localparam logic [3:0] WIN        = 4'(WIN_SCORE);

  state_t     state;
  logic [7:0] frame_cnt;
  logic [4:0] btn_raw, sync1, sync2;
  logic       start_prev, start_p;
  logic       paddle_en;

  function automatic logic [3:0] sat_inc(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

  assign btn_raw   = {start, p2_left, p2_right, p1_left, p1_right};
  assign paddle_en = (state == SERVE) || (state == PLAY);

  always_ff @(posedge pixel_clk) begin
    if (rst) begin
      sync1      <= '0;
      sync2      <= '0;
      start_prev <= 1'b0;
      start_p    <= 1'b0;
      p1_right_o <= 1'b0;
      p1_left_o  <= 1'b0;
      p2_right_o <= 1'b0;
      p2_left_o  <= 1'b0;
    end else begin
      sync1      <= btn_raw;
      sync2      <= sync1;
      start_prev <= sync2[4];
      start_p    <= sync2[4] & ~start_prev;
      p1_right_o <= sync2[0] & paddle_en;
      p1_left_o  <= sync2[1] & paddle_en;
      p2_right_o <= sync2[2] & paddle_en;
      p2_left_o  <= sync2[3] & paddle_en;
    end
  end

  always_ff @(posedge pixel_clk) begin
    if (rst) begin
      state     <= IDLE;
      frame_cnt <= '0;
      score1    <= '0;
      score2    <= '0;
      ball_en   <= 1'b0;
      serve_dir <= 1'b0;
      obj_rst   <= 1'b0;
      game_over <= 1'b0;
      winner    <= 1'b0;
    end else begin
      obj_rst <= 1'b0;
      case (state)
        IDLE, OVER: begin
          if (start_p) begin
            score1    <= '0;
            score2    <= '0;
            serve_dir <= 1'b0;
            game_over <= 1'b0;
            obj_rst   <= 1'b1;
            frame_cnt <= '0;
            state     <= SERVE;
          end
        end
        SERVE: begin
          if (fsync) begin
            if (frame_cnt == SERVE_LAST) begin
              frame_cnt <= '0;
              ball_en   <= 1'b1;
              state     <= PLAY;
            end else begin
              frame_cnt <= frame_cnt + 8'd1;
            end
          end
        end
        PLAY: begin
          // miss_top wins a simultaneous double miss; the loser receives the serve
          if (miss_top) begin
            score2    <= sat_inc(score2);
            serve_dir <= 1'b0;
            ball_en   <= 1'b0;
            frame_cnt <= '0;
            state     <= SCORE;
          end else if (miss_bottom) begin
            score1    <= sat_inc(score1);
            serve_dir <= 1'b1;
            ball_en   <= 1'b0;
            frame_cnt <= '0;
            state     <= SCORE;
          end
        end
        SCORE: begin
          if (fsync) begin
            if (frame_cnt == PAUSE_LAST) begin
              frame_cnt <= '0;
              if (score1 == WIN || score2 == WIN) begin
                game_over <= 1'b1;
                winner    <= (score2 == WIN);
                state     <= OVER;
              end else begin
                obj_rst <= 1'b1;
                state   <= SERVE;
              end
            end else begin
              frame_cnt <= frame_cnt + 8'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Randomised game-level bench for pong_game_ctrl: a score/phase model drives
// rallies with random miss kinds, fsync spacing and button patterns.
module tb_pong_game_ctrl;

  localparam int SERVE_FRAMES = 3;
  localparam int PAUSE_FRAMES = 2;
  localparam int WIN_SCORE    = 4;

  logic       pixel_clk = 1'b0;
  logic       rst, fsync, start, miss_top, miss_bottom;
  logic [3:0] btn;
  logic       p1_right_o, p1_left_o, p2_right_o, p2_left_o;
  logic       ball_en, serve_dir, obj_rst, game_over, winner;
  logic [3:0] score1, score2;
  logic [3:0] paddles;

  int compared   = 0;
  int mismatched = 0;

  int  m_s1, m_s2, m_sd;
  bit  m_over;

  always #5 pixel_clk = ~pixel_clk;

  assign paddles = {p2_left_o, p2_right_o, p1_left_o, p1_right_o};

  pong_game_ctrl #(
    .SERVE_FRAMES(SERVE_FRAMES),
    .PAUSE_FRAMES(PAUSE_FRAMES),
    .WIN_SCORE   (WIN_SCORE)
  ) dut (
    .pixel_clk  (pixel_clk),
    .rst        (rst),
    .fsync      (fsync),
    .start      (start),
    .p1_right   (btn[0]),
    .p1_left    (btn[1]),
    .p2_right   (btn[2]),
    .p2_left    (btn[3]),
    .miss_top   (miss_top),
    .miss_bottom(miss_bottom),
    .p1_right_o (p1_right_o),
    .p1_left_o  (p1_left_o),
    .p2_right_o (p2_right_o),
    .p2_left_o  (p2_left_o),
    .ball_en    (ball_en),
    .serve_dir  (serve_dir),
    .obj_rst    (obj_rst),
    .score1     (score1),
    .score2     (score2),
    .game_over  (game_over),
    .winner     (winner)
  );

  task automatic tick();
    @(posedge pixel_clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic gap();
    repeat ($urandom_range(1, 3)) tick();
  endtask

  task automatic check_scores(input string tag);
    check({tag, "_score1"}, {4'd0, score1}, 8'(m_s1));
    check({tag, "_score2"}, {4'd0, score2}, 8'(m_s2));
  endtask

  // start held 5 cycles: one start_p, obj_rst exactly once, 4 edges after the rise
  task automatic do_start();
    int pulses = 0;
    int first  = 0;
    start = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      tick();
      if (c == 5) start = 1'b0;
      if (obj_rst === 1'b1) begin
        pulses++;
        if (first == 0) first = c;
      end
    end
    check("start_objrst_count", 8'(pulses), 8'd1);
    check("start_objrst_latency", 8'(first), 8'd4);
    m_s1 = 0; m_s2 = 0; m_sd = 0; m_over = 1'b0;
    check_scores("start");
    check("start_serve_dir", {7'd0, serve_dir}, 8'd0);
    check("start_game_over", {7'd0, game_over}, 8'd0);
    check("start_ball_en", {7'd0, ball_en}, 8'd0);
  endtask

  // in SERVE: button latency, then exactly SERVE_FRAMES fsyncs until ball_en
  task automatic run_serve();
    logic [3:0] v, w;
    v = 4'($urandom);
    w = 4'($urandom);
    btn = v;
    repeat (3) tick();
    check("serve_paddles", {4'd0, paddles}, {4'd0, v});
    btn = w;
    repeat (2) tick();
    check("serve_paddles_old", {4'd0, paddles}, {4'd0, v});
    tick();
    check("serve_paddles_new", {4'd0, paddles}, {4'd0, w});
    for (int k = 1; k <= SERVE_FRAMES; k++) begin
      gap();
      check("serve_frozen", {7'd0, ball_en}, 8'd0);
      fsync = 1'b1;
      tick();
      fsync = 1'b0;
      check("serve_release", {7'd0, ball_en}, (k == SERVE_FRAMES) ? 8'd1 : 8'd0);
    end
  endtask

  // kind: 0 miss_top, 1 miss_bottom, 2 both at once
  task automatic rally(input int kind);
    repeat ($urandom_range(2, 6)) begin
      fsync = ($urandom_range(0, 1) == 1);
      tick();
      fsync = 1'b0;
    end
    check("play_ball_en", {7'd0, ball_en}, 8'd1);
    check("play_paddles", {4'd0, paddles}, {4'd0, btn});
    fsync       = ($urandom_range(0, 1) == 1);
    miss_top    = (kind != 1);
    miss_bottom = (kind != 0);
    tick();
    fsync = 1'b0; miss_top = 1'b0; miss_bottom = 1'b0;
    if (kind == 1) begin
      m_s1 = (m_s1 < 15) ? m_s1 + 1 : 15;
      m_sd = 1;
    end else begin
      m_s2 = (m_s2 < 15) ? m_s2 + 1 : 15;
      m_sd = 0;
    end
    check("miss_ball_en", {7'd0, ball_en}, 8'd0);
    check_scores("miss");
    check("miss_serve_dir", {7'd0, serve_dir}, 8'(m_sd));
    tick();
    check("score_paddles_gated", {4'd0, paddles}, 8'd0);
    miss_top = 1'b1;
    tick();
    miss_top = 1'b0;
    check_scores("score_ignore_miss");
    for (int k = 1; k <= PAUSE_FRAMES; k++) begin
      gap();
      check("pause_objrst_idle", {7'd0, obj_rst}, 8'd0);
      fsync = 1'b1;
      tick();
      fsync = 1'b0;
      if (k < PAUSE_FRAMES) begin
        check("pause_game_over", {7'd0, game_over}, 8'd0);
      end else begin
        m_over = (m_s1 == WIN_SCORE) || (m_s2 == WIN_SCORE);
        check("pause_end_game_over", {7'd0, game_over}, 8'(m_over));
        check("pause_end_objrst", {7'd0, obj_rst}, m_over ? 8'd0 : 8'd1);
        if (m_over) check("winner", {7'd0, winner}, (m_s2 == WIN_SCORE) ? 8'd1 : 8'd0);
        tick();
        check("objrst_single", {7'd0, obj_rst}, 8'd0);
        check("pause_end_ball_en", {7'd0, ball_en}, 8'd0);
      end
    end
  endtask

  initial begin
    int r;
    rst = 1'b1; fsync = 1'b0; start = 1'b0; miss_top = 1'b0; miss_bottom = 1'b0;
    btn = 4'h0;
    m_s1 = 0; m_s2 = 0; m_sd = 0; m_over = 1'b0;
    repeat (3) tick();
    check("rst_ball_en", {7'd0, ball_en}, 8'd0);
    check("rst_game_over", {7'd0, game_over}, 8'd0);
    check("rst_obj_rst", {7'd0, obj_rst}, 8'd0);
    check_scores("rst");
    rst = 1'b0;

    btn = 4'hF;
    repeat (4) tick();
    check("idle_paddles_gated", {4'd0, paddles}, 8'd0);
    fsync = 1'b1; tick(); fsync = 1'b0;
    miss_bottom = 1'b1; tick(); miss_bottom = 1'b0;
    check("idle_ball_en", {7'd0, ball_en}, 8'd0);
    check_scores("idle_ignore_miss");

    do_start();
    r = 0;
    while (!m_over && r < 2 * WIN_SCORE) begin
      run_serve();
      rally((r == 0) ? 2 : (r == 1) ? 1 : $urandom_range(0, 2));
      r++;
    end
    check("game_ended", {7'd0, game_over}, 8'd1);
    miss_top = 1'b1; tick(); miss_top = 1'b0;
    fsync = 1'b1; tick(); fsync = 1'b0;
    tick();
    check_scores("over_ignore_miss");
    check("over_hold", {7'd0, game_over}, 8'd1);
    check("over_paddles_gated", {4'd0, paddles}, 8'd0);

    do_start();
    for (int i = 0; i < 3; i++) begin
      run_serve();
      rally(1);
    end
    run_serve();
    check_scores("pre_reset");
    btn = 4'hF;
    repeat (3) tick();
    rst = 1'b1;
    tick();
    check("mid_rst_ball_en", {7'd0, ball_en}, 8'd0);
    check("mid_rst_serve_dir", {7'd0, serve_dir}, 8'd0);
    check("mid_rst_obj_rst", {7'd0, obj_rst}, 8'd0);
    check("mid_rst_game_over", {7'd0, game_over}, 8'd0);
    check("mid_rst_winner", {7'd0, winner}, 8'd0);
    check("mid_rst_paddles", {4'd0, paddles}, 8'd0);
    m_s1 = 0; m_s2 = 0;
    check_scores("mid_rst");
    rst = 1'b0;
    repeat (SERVE_FRAMES + 1) begin
      fsync = 1'b1; tick(); fsync = 1'b0; tick();
    end
    check("post_rst_idle_ball_en", {7'd0, ball_en}, 8'd0);
    check("post_rst_idle_paddles", {4'd0, paddles}, 8'd0);
    check("post_rst_idle_obj_rst", {7'd0, obj_rst}, 8'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
